seg_scanner: RTL and testbench
==============================

SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter BASE_ADDR, 32'h00000200, byte address of digit word 0; digit k is at BASE_ADDR+4k, k=0..3.
REQ-002 Parameter REFRESH_DIV, 100000, SHOW dwell per digit in clk cycles, legal range 2..2^20.
REQ-003 Parameter FETCH_TIMEOUT, 16, maximum FETCH cycles without mem_ready, legal range 2..255.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 enable  in  1  1 = scanning runs; 0 = stop and blank.
REQ-007 mem_req  out  1  data-memory read request, held until accepted.
REQ-008 mem_addr  out  32  read byte address, valid while mem_req=1.
REQ-009 mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
REQ-010 mem_ready  in  1  read accept/data-valid strobe; ignored while mem_req=0.
REQ-011 AN  out  4  digit enables, active-low, one-hot-low or 4'b1111.
REQ-012 BCD  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; 8'hFF = blank.
REQ-013 fetch_err  out  1  single-cycle pulse on fetch timeout.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, FETCH and SHOW, plus a 2-bit slot counter and a dwell counter.
REQ-015 In IDLE, AN=4'b1111, BCD=8'hFF and mem_req=0; enable=1 SHALL cause entry to FETCH on the next cycle.
REQ-016 On FETCH entry, mem_req=1 and mem_addr=BASE_ADDR+4*slot SHALL be registered; both SHALL remain stable until the acceptance cycle; AN=4'b1111 throughout FETCH.
REQ-017 A fetch SHALL be accepted in the first FETCH cycle with mem_ready=1; mem_rdata is captured that cycle, mem_req=0 the next cycle, and the state moves to SHOW.
REQ-018 The read latency SHALL be 1 cycle when mem_ready is already 1 in the first FETCH cycle; AN/BCD update in the first SHOW cycle.
REQ-019 If FETCH_TIMEOUT FETCH cycles elapse without mem_ready, the block SHALL drop mem_req, pulse fetch_err for 1 cycle, and enter SHOW with BCD=8'hFF for that slot.
REQ-020 In SHOW, AN SHALL be ~(4'b0001<<slot) and BCD SHALL be decode(word[3:0]), with bit7=~word[4]; word[31:5] is ignored.
REQ-021 Decode SHALL be the hex 7-segment table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (dp bit set, i.e. off).
REQ-022 SHOW SHALL last exactly REFRESH_DIV cycles; at the terminal count, slot SHALL increment mod 4 (3 wraps to 0), and the next state is FETCH if enable=1, else IDLE.
REQ-023 enable=0 during SHOW SHALL force IDLE on the next cycle; slot is retained, and resumption starts at the same slot.
REQ-024 enable=0 during FETCH SHALL NOT abort a pending request; the fetch completes or times out, then the state goes to IDLE instead of SHOW.
REQ-025 mem_ready=1 in the same cycle as the timeout expiry SHALL count as acceptance, with no fetch_err.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE, slot=0, dwell=0, mem_req=0, mem_addr=BASE_ADDR, AN=4'b1111, BCD=8'hFF and fetch_err=0, regardless of state, including mid-FETCH.
REQ-027 The first mem_req after reset release with enable=1 SHALL occur 1 cycle after release, addressing BASE_ADDR.

Structure
REQ-028 A shared package seg_pkg SHALL hold the state enum, the 16-entry segment table, SEG_BLANK=8'hFF, AN_OFF=4'b1111 and the parameter defaults.
REQ-029 The segment decode SHALL be a separate combinational sub-module seg7_decode (in 5 bits, out 8 bits), instanced once.
REQ-030 All outputs SHALL be registered; there is no combinational path from mem_ready or mem_rdata to any output.

Verification (REFRESH_DIV=4, FETCH_TIMEOUT=4, BASE_ADDR=32'h200)
REQ-031 Words 0..3 = 1,2,3,4, mem_ready always 1 -> AN cycles 1110,1101,1011,0111 with BCD F9,A4,B0,99, each shown 4 cycles, mem_addr 200,204,208,20C.
REQ-032 Word0=32'h18, mem_ready delayed 3 cycles -> mem_req held 3 cycles at addr 200 with AN=1111, then AN=1110 and BCD=00.
REQ-033 mem_ready held 0 -> fetch_err pulses after 4 cycles, AN=1110 with BCD=FF, then the fetch of slot 1 proceeds.
REQ-034 mem_ready=1 on the 4th FETCH cycle -> accepted, no fetch_err, digit displayed.
REQ-035 enable dropped in SHOW of slot 2, restored 5 cycles later -> IDLE with AN=1111 during the gap, next fetch at 208.
REQ-036 reset=0 asserted mid-FETCH -> next cycle mem_req=0, AN=1111, BCD=FF; after release the first fetch is at 200.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM state encoding,
// hex segment table, blanking values and parameter defaults.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR     = 32'h0000_0200;
  localparam int          DEF_REFRESH_DIV   = 100000;
  localparam int          DEF_FETCH_TIMEOUT = 16;

  // Wide enough for the largest legal dwell (2^20 cycles, counted 0..2^20-1).
  localparam int DWELL_W = 20;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] an_for_slot(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder; bit 4 of the input lights the decimal point.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [4:0] din,
  output logic [7:0] seg
);

  assign seg = {~din[4], SEG_TABLE[din[3:0]][6:0]};

endmodule

// File: rtl/seg_scanner.sv
// Four-digit multiplexed display scanner: fetches each digit word from data memory,
// then drives it on the active-low anode/segment outputs for a fixed dwell.
module seg_scanner
  import seg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          REFRESH_DIV   = DEF_REFRESH_DIV,
  parameter int          FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        fetch_err
);

  localparam logic [DWELL_W-1:0] SHOW_LAST  = DWELL_W'(REFRESH_DIV - 1);
  localparam logic [DWELL_W-1:0] FETCH_LAST = DWELL_W'(FETCH_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_e              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [3:0]          an_q, an_d;
  logic [7:0]          bcd_q, bcd_d;
  logic                fetch_err_q, fetch_err_d;
  logic [7:0]          seg_dec;

  // Only the low five bits of a digit word are meaningful.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:5];

  seg7_decode u_decode (
    .din (mem_rdata[4:0]),
    .seg (seg_dec)
  );

  function automatic logic [31:0] slot_addr(input logic [1:0] s);
    return BASE_ADDR + {28'd0, s, 2'b00};
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d     = state_q;
    slot_d      = slot_q;
    dwell_d     = dwell_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    an_d        = an_q;
    bcd_d       = bcd_q;
    fetch_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        an_d      = AN_OFF;
        bcd_d     = SEG_BLANK;
        mem_req_d = 1'b0;
        if (enable) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = slot_addr(slot_q);
          dwell_d    = '0;
        end
      end

      ST_FETCH: begin
        // Acceptance wins over an expiry landing in the same cycle.
        if (mem_ready || dwell_q == FETCH_LAST) begin
          mem_req_d   = 1'b0;
          dwell_d     = '0;
          fetch_err_d = ~mem_ready;
          if (enable) begin
            state_d = ST_SHOW;
            an_d    = an_for_slot(slot_q);
            bcd_d   = mem_ready ? seg_dec : SEG_BLANK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      ST_SHOW: begin
        if (dwell_q == SHOW_LAST) begin
          slot_d  = slot_q + 2'd1;
          dwell_d = '0;
          an_d    = AN_OFF;
          bcd_d   = SEG_BLANK;
          if (enable) begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = slot_addr(slot_q + 2'd1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!enable) begin
          // Slot is kept so scanning resumes on the digit that was interrupted.
          state_d = ST_IDLE;
          dwell_d = '0;
          an_d    = AN_OFF;
          bcd_d   = SEG_BLANK;
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= 2'd0;
      dwell_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      an_q        <= AN_OFF;
      bcd_q       <= SEG_BLANK;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      dwell_q     <= dwell_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      an_q        <= an_d;
      bcd_q       <= bcd_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign AN        = an_q;
  assign BCD       = bcd_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner: table vectors, hand-written enable/reset
// sequences and randomized words/latencies against a segment-level reference model.
module tb_seg_scanner;

  localparam int          RD   = 4;
  localparam int          FT   = 4;
  localparam logic [31:0] BASE = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        fetch_err;

  int n_vec = 0;
  int n_bad = 0;
  int slot_exp = 0;

  typedef struct {
    logic [31:0] word;
    int          delay;
    logic [7:0]  bcd;
  } vec_t;

  vec_t vecs [12];

  // Lit segments of each hex glyph; the model clears those bits of an all-off byte.
  string seg_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg_scanner #(
    .BASE_ADDR     (BASE),
    .REFRESH_DIV   (RD),
    .FETCH_TIMEOUT (FT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .AN        (AN),
    .BCD       (BCD),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_bcd(input logic [31:0] word);
    logic [7:0] seg;
    string      s;
    seg = 8'hFF;
    s   = seg_lit[int'(word % 16)];
    for (int i = 0; i < s.len(); i++) seg[s[i] - 8'd97] = 1'b0;
    if ((word / 16) % 2 == 1) seg[7] = 1'b0;
    return seg;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (slot %0d, t=%0t)", name, act, exp, slot_exp, $time);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_an"}, {28'd0, AN}, 32'hF);
    check({tag, "_bcd"}, {24'd0, BCD}, 32'hFF);
    check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  // Entered at the negedge of the first FETCH cycle of slot_exp; checks the fetch
  // and show_n SHOW cycles, leaving the bench at the negedge that follows.
  task automatic run_slot(input int delay, input logic [31:0] word, input logic [7:0] exp_bcd,
                          input int show_n);
    int         nf;
    bit         to;
    logic [3:0] an_exp;
    to = (delay >= FT);
    nf = to ? FT : delay + 1;
    an_exp = 4'b1111;
    an_exp[slot_exp] = 1'b0;
    for (int c = 0; c < nf; c++) begin
      check("fetch_req", {31'd0, mem_req}, 32'd1);
      check("fetch_addr", mem_addr, BASE + 32'(4 * slot_exp));
      check("fetch_an", {28'd0, AN}, 32'hF);
      check("fetch_err", {31'd0, fetch_err}, 32'd0);
      mem_ready = (c == delay);
      mem_rdata = (c == delay) ? word : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < show_n; c++) begin
      check("show_req", {31'd0, mem_req}, 32'd0);
      check("show_an", {28'd0, AN}, {28'd0, an_exp});
      check("show_bcd", {24'd0, BCD}, to ? 32'hFF : {24'd0, exp_bcd});
      check("show_err", {31'd0, fetch_err}, {31'd0, (to && c == 0)});
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (show_n == RD) slot_exp = (slot_exp + 1) % 4;
  endtask

  initial begin
    logic [31:0] w;
    int          d;

    vecs[0]  = '{32'h0000_0001, 0, 8'hF9};
    vecs[1]  = '{32'h0000_0002, 0, 8'hA4};
    vecs[2]  = '{32'h0000_0003, 0, 8'hB0};
    vecs[3]  = '{32'h0000_0004, 0, 8'h99};
    vecs[4]  = '{32'h0000_0018, 2, 8'h00};
    vecs[5]  = '{32'h0000_0005, 9, 8'hFF};
    vecs[6]  = '{32'h0000_001F, 3, 8'h0E};
    vecs[7]  = '{32'hFFFF_FFEA, 1, 8'h88};
    vecs[8]  = '{32'hABCD_1230, 0, 8'h40};
    vecs[9]  = '{32'h0000_000B, 0, 8'h83};
    vecs[10] = '{32'h0000_000C, 2, 8'hC6};
    vecs[11] = '{32'h7654_321D, 3, 8'h21};

    reset     = 1'b0;
    enable    = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check_blank("reset");
    check("reset_addr", mem_addr, BASE);

    reset = 1'b1;
    @(negedge clk);
    slot_exp = 0;

    foreach (vecs[i]) run_slot(vecs[i].delay, vecs[i].word, vecs[i].bcd, RD);

    // enable dropped during FETCH: the read completes, then IDLE, same slot refetched
    check("fe_req", {31'd0, mem_req}, 32'd1);
    enable    = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("fe_req_hold", {31'd0, mem_req}, 32'd1);
    check("fe_an", {28'd0, AN}, 32'hF);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0003;
    @(negedge clk);
    check_blank("fe_idle");
    mem_ready = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    run_slot(0, 32'h0000_0003, 8'hB0, RD);
    run_slot(0, 32'h0000_0009, 8'h90, RD);

    // enable dropped in SHOW of slot 2, scanning resumes at 208
    run_slot(0, 32'h0000_0006, 8'h82, 2);
    check("se_an", {28'd0, AN}, 32'hB);
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_blank("se_gap");
      if (i == 4) enable = 1'b1;
      @(negedge clk);
    end
    run_slot(0, 32'h0000_0006, 8'h82, RD);

    // reset asserted mid-FETCH of slot 3
    check("rf_req", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_blank("rf_reset");
    check("rf_addr", mem_addr, BASE);
    reset = 1'b1;
    @(negedge clk);
    slot_exp = 0;
    run_slot(0, 32'h0000_0002, 8'hA4, RD);

    // randomized words and read latencies, some past the timeout
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      d = int'($urandom_range(0, 5));
      run_slot(d, w, model_bcd(w), RD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
